// File: rtl/systolic_feeder_pkg.sv
// Shared configuration for the systolic array and its input-side feeder.
package Config;

  localparam int unsigned sys_rows   = 4;
  localparam int unsigned sys_cols   = 2;
  localparam int unsigned A_BITWIDTH = 8;
  localparam int unsigned W_BITWIDTH = 8;
  localparam int unsigned P_BITWIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_skew_line.sv
// Fixed-depth delay line for one array row's {enable, data} pair.
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [DW-1:0] data_i,
  output logic          en_o,
  output logic [DW-1:0] data_o
);

  if (DEPTH == 0) begin : g_pass
    assign en_o   = en_i;
    assign data_o = data_i;
  end else begin : g_sr
    logic [DEPTH-1:0]         en_q, en_d;
    logic [DEPTH-1:0][DW-1:0] data_q, data_d;

    // Shift one stage per cycle; stage 0 takes the row input.
    always_comb begin
      en_d      = en_q;
      data_d    = data_q;
      en_d[0]   = en_i;
      data_d[0] = data_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        en_d[i]   = en_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end

    // Delay-line registers, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        en_q   <= '0;
        data_q <= '0;
      end else begin
        en_q   <= en_d;
        data_q <= data_d;
      end
    end

    assign en_o   = en_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Drives a weight-stationary systolic array: weight load, switch pulse,
// and row-skewed activation streaming, with a drain before signalling done.
module systolic_feeder
  import Config::*;
#(
  parameter int unsigned ROWS = sys_rows,
  parameter int unsigned COLS = sys_cols,
  parameter int unsigned AW   = A_BITWIDTH,
  parameter int unsigned WW   = W_BITWIDTH,
  parameter int unsigned PW   = P_BITWIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PW-1:0]             cfg_bias,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [COLS-1:0][WW-1:0]   w_data,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [ROWS-1:0][AW-1:0]   a_data,
  input  logic                      a_last,
  output logic [COLS-1:0]           wfetch,
  output logic [COLS-1:0][WW-1:0]   i_wdata,
  output logic                      switch,
  output logic [PW-1:0]             bias,
  output logic [ROWS-1:0]           if_en,
  output logic [ROWS-1:0][AW-1:0]   if_data,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CW = $clog2(ROWS + 1);

  feeder_state_e             state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      w_ready_q, w_ready_d;
  logic                      a_ready_q, a_ready_d;
  logic [COLS-1:0]           wfetch_q, wfetch_d;
  logic [COLS-1:0][WW-1:0]   i_wdata_q, i_wdata_d;
  logic                      switch_q, switch_d;
  logic [PW-1:0]             bias_q, bias_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [ROWS-1:0]           row_en_q, row_en_d;
  logic [ROWS-1:0][AW-1:0]   row_data_q, row_data_d;
  logic                      w_hs, a_hs;

  assign w_hs = w_valid & w_ready_q;
  assign a_hs = a_valid & a_ready_q;

  // Next-state, counters and registered output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wfetch_d   = '0;
    i_wdata_d  = i_wdata_q;
    switch_d   = 1'b0;
    bias_d     = bias_q;
    done_d     = 1'b0;
    row_en_d   = '0;
    row_data_d = '0;

    if (w_hs) begin
      wfetch_d  = '1;
      i_wdata_d = w_data;
    end
    if (a_hs) begin
      row_en_d   = '1;
      row_data_d = a_data;
    end

    case (state_q)
      IDLE: begin
        if (w_hs) begin
          bias_d  = cfg_bias;
          cnt_d   = CW'(1);
          state_d = (ROWS == 1) ? SWITCH : LOAD_W;
        end
      end
      LOAD_W: begin
        if (w_hs) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(ROWS - 1)) state_d = SWITCH;
        end
      end
      SWITCH: begin
        switch_d = 1'b1;
        cnt_d    = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        if (a_hs && a_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ROWS - 1)) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    w_ready_d = (state_d == IDLE) || (state_d == LOAD_W);
    a_ready_d = (state_d == STREAM);
    busy_d    = (state_d != IDLE) || done_d;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      w_ready_q  <= 1'b1;
      a_ready_q  <= 1'b0;
      wfetch_q   <= '0;
      i_wdata_q  <= '0;
      switch_q   <= 1'b0;
      bias_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      row_en_q   <= '0;
      row_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      w_ready_q  <= w_ready_d;
      a_ready_q  <= a_ready_d;
      wfetch_q   <= wfetch_d;
      i_wdata_q  <= i_wdata_d;
      switch_q   <= switch_d;
      bias_q     <= bias_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      row_en_q   <= row_en_d;
      row_data_q <= row_data_d;
    end
  end

  logic [ROWS-1:0]         skew_en;
  logic [ROWS-1:0][AW-1:0] skew_data;

  // Row 0 leaves straight from its input register; row r adds r stages.
  assign skew_en[0]   = row_en_q[0];
  assign skew_data[0] = row_data_q[0];

  for (genvar r = 1; r < int'(ROWS); r++) begin : g_row
    skew_line #(
      .DEPTH (r),
      .DW    (AW)
    ) u_skew (
      .clk    (clk),
      .rst_n  (rst),
      .en_i   (row_en_q[r]),
      .data_i (row_data_q[r]),
      .en_o   (skew_en[r]),
      .data_o (skew_data[r])
    );
  end

  assign w_ready = w_ready_q;
  assign a_ready = a_ready_q;
  assign wfetch  = wfetch_q;
  assign i_wdata = i_wdata_q;
  assign switch  = switch_q;
  assign bias    = bias_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign if_en   = skew_en;
  assign if_data = skew_data;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed table, directed corner sequences,
// and random traffic against a cycle-timeline reference model.
module tb_systolic_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 2;
  localparam int AW   = 8;
  localparam int WW   = 8;
  localparam int PW   = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [PW-1:0]           cfg_bias = '0;
  logic                    w_valid = 1'b0;
  logic                    w_ready;
  logic [COLS-1:0][WW-1:0] w_data = '0;
  logic                    a_valid = 1'b0;
  logic                    a_ready;
  logic [ROWS-1:0][AW-1:0] a_data = '0;
  logic                    a_last = 1'b0;
  logic [COLS-1:0]         wfetch;
  logic [COLS-1:0][WW-1:0] i_wdata;
  logic                    switch;
  logic [PW-1:0]           bias;
  logic [ROWS-1:0]         if_en;
  logic [ROWS-1:0][AW-1:0] if_data;
  logic                    busy;
  logic                    done;

  systolic_feeder #(
    .ROWS(ROWS), .COLS(COLS), .AW(AW), .WW(WW), .PW(PW)
  ) dut (
    .clk(clk), .rst(rst), .cfg_bias(cfg_bias),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .wfetch(wfetch), .i_wdata(i_wdata), .switch(switch), .bias(bias),
    .if_en(if_en), .if_data(if_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sw_cyc = -1;
  always @(negedge clk) if (switch) sw_cyc = cyc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic                 wv;
    logic [COLS*WW-1:0]   wd;
    logic [PW-1:0]        cb;
    logic                 av;
    logic [ROWS*AW-1:0]   ad;
    logic                 al;
    logic                 e_wr;
    logic                 e_ar;
    logic [COLS-1:0]      e_wf;
    logic [COLS*WW-1:0]   e_iw;
    logic                 e_sw;
    logic [PW-1:0]        e_bias;
    logic [ROWS-1:0]      e_en;
    logic [ROWS*AW-1:0]   e_dat;
    logic                 e_busy;
    logic                 e_done;
  } vec_t;

  vec_t tbl [12];

  // ---------------- reference model ----------------
  bit                  m_in_tile, m_done_pend, m_prev_hw;
  int                  m_beats, m_lastbeat, m_done_c, last_c;
  logic [COLS*WW-1:0]  m_wd;
  logic [PW-1:0]       m_bias;
  logic [ROWS-1:0]     h_en;
  logic [ROWS*AW-1:0]  h_dat [ROWS];

  task automatic model_reset();
    m_in_tile   = 0;
    m_done_pend = 0;
    m_prev_hw   = 0;
    m_beats     = 0;
    m_lastbeat  = -100;
    m_done_c    = -100;
    m_wd        = '0;
    m_bias      = '0;
    h_en        = '0;
    for (int k = 0; k < ROWS; k++) h_dat[k] = '0;
  endtask

  // One clock cycle: check outputs against the model, then drive inputs.
  task automatic mcycle(input bit wv, input logic [COLS*WW-1:0] wd, input logic [PW-1:0] cb,
                        input bit av, input logic [ROWS*AW-1:0] ad, input bit al);
    bit wr, ar, e_sw, e_done, hw, ha;
    logic [ROWS-1:0]    e_en;
    logic [ROWS*AW-1:0] e_dat;
    int c;
    @(posedge clk); #1;
    c = cyc;
    last_c = c;
    e_done = m_done_pend && (c == m_done_c);
    if (e_done) begin
      m_done_pend = 0;
      m_in_tile   = 0;
    end
    wr   = !m_in_tile || (m_beats < ROWS);
    ar   = m_in_tile && (m_beats == ROWS) && (c >= m_lastbeat + 2) && !m_done_pend;
    e_sw = m_in_tile && (m_beats == ROWS) && (c == m_lastbeat + 2);
    e_dat = '0;
    for (int r = 0; r < ROWS; r++) begin
      e_en[r] = h_en[r];
      if (h_en[r]) e_dat[r*AW +: AW] = h_dat[r][r*AW +: AW];
    end
    chk("w_ready", 64'(w_ready), 64'(wr));
    chk("a_ready", 64'(a_ready), 64'(ar));
    chk("wfetch",  64'(wfetch),  m_prev_hw ? 64'(2'b11) : 64'd0);
    chk("i_wdata", 64'(i_wdata), 64'(m_wd));
    chk("switch",  64'(switch),  64'(e_sw));
    chk("bias",    64'(bias),    64'(m_bias));
    chk("if_en",   64'(if_en),   64'(e_en));
    chk("if_data", 64'(if_data), 64'(e_dat));
    chk("busy",    64'(busy),    64'(m_in_tile || e_done));
    chk("done",    64'(done),    64'(e_done));

    w_valid = wv; w_data = wd; cfg_bias = cb;
    a_valid = av; a_data = ad; a_last = al;

    hw = wv && wr;
    ha = av && ar;
    m_prev_hw = hw;
    if (hw) begin
      m_wd = wd;
      if (!m_in_tile) begin
        m_in_tile = 1;
        m_beats   = 1;
        m_bias    = cb;
      end else begin
        m_beats++;
      end
      if (m_beats == ROWS) m_lastbeat = c;
    end
    for (int k = ROWS - 1; k > 0; k--) begin
      h_en[k]  = h_en[k-1];
      h_dat[k] = h_dat[k-1];
    end
    h_en[0]  = ha;
    h_dat[0] = ad;
    if (ha && al) begin
      m_done_pend = 1;
      m_done_c    = c + ROWS + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) mcycle(0, '0, '0, 0, '0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk); #1;
    w_valid = 0; a_valid = 0; a_last = 0;
    rst = 0;
    #1;
    chk("rst_wfetch",  64'(wfetch),  64'd0);
    chk("rst_i_wdata", 64'(i_wdata), 64'd0);
    chk("rst_switch",  64'(switch),  64'd0);
    chk("rst_bias",    64'(bias),    64'd0);
    chk("rst_if_en",   64'(if_en),   64'd0);
    chk("rst_if_data", 64'(if_data), 64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_done",    64'(done),    64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd1);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1;
  endtask

  initial begin
    int t0;
    tbl[0]  = '{1'b1, 16'h0201, 16'h1234, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000, 4'h0, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h0403, 16'h1234, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, 2'b11, 16'h0201, 1'b0, 16'h1234, 4'h0, 32'h0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 16'h0605, 16'h5678, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, 2'b11, 16'h0403, 1'b0, 16'h1234, 4'h0, 32'h0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 16'h0807, 16'h5678, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, 2'b11, 16'h0605, 1'b0, 16'h1234, 4'h0, 32'h0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 16'h5678, 1'b1, 32'hDEADBEEF, 1'b1,
                1'b0, 1'b0, 2'b11, 16'h0807, 1'b0, 16'h1234, 4'h0, 32'h0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 16'hAAAA, 16'h0000, 1'b1, 32'h281E140A, 1'b1,
                1'b0, 1'b1, 2'b00, 16'h0807, 1'b1, 16'h1234, 4'h0, 32'h0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, 1'b0,
                1'b0, 1'b0, 2'b00, 16'h0807, 1'b0, 16'h1234, 4'b0001, 32'h0000000A, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, 1'b0,
                1'b0, 1'b0, 2'b00, 16'h0807, 1'b0, 16'h1234, 4'b0010, 32'h00001400, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, 1'b0,
                1'b0, 1'b0, 2'b00, 16'h0807, 1'b0, 16'h1234, 4'b0100, 32'h001E0000, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, 1'b0,
                1'b0, 1'b0, 2'b00, 16'h0807, 1'b0, 16'h1234, 4'b1000, 32'h28000000, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, 2'b00, 16'h0807, 1'b0, 16'h1234, 4'h0, 32'h0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, 1'b0,
                1'b1, 1'b0, 2'b00, 16'h0807, 1'b0, 16'h1234, 4'h0, 32'h0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      chk($sformatf("t%0d_w_ready", i), 64'(w_ready), 64'(tbl[i].e_wr));
      chk($sformatf("t%0d_a_ready", i), 64'(a_ready), 64'(tbl[i].e_ar));
      chk($sformatf("t%0d_wfetch",  i), 64'(wfetch),  64'(tbl[i].e_wf));
      chk($sformatf("t%0d_i_wdata", i), 64'(i_wdata), 64'(tbl[i].e_iw));
      chk($sformatf("t%0d_switch",  i), 64'(switch),  64'(tbl[i].e_sw));
      chk($sformatf("t%0d_bias",    i), 64'(bias),    64'(tbl[i].e_bias));
      chk($sformatf("t%0d_if_en",   i), 64'(if_en),   64'(tbl[i].e_en));
      chk($sformatf("t%0d_if_data", i), 64'(if_data), 64'(tbl[i].e_dat));
      chk($sformatf("t%0d_busy",    i), 64'(busy),    64'(tbl[i].e_busy));
      chk($sformatf("t%0d_done",    i), 64'(done),    64'(tbl[i].e_done));
      w_valid  = tbl[i].wv;
      w_data   = tbl[i].wd;
      cfg_bias = tbl[i].cb;
      a_valid  = tbl[i].av;
      a_data   = tbl[i].ad;
      a_last   = tbl[i].al;
    end

    // Fresh start for the model-checked sections.
    do_reset();

    // Weight gap of three cycles after beat 2; bias changes mid-tile.
    mcycle(1, 16'h0201, 16'h1234, 0, '0, 0);
    t0 = last_c;
    mcycle(1, 16'h0403, 16'h1234, 0, '0, 0);
    idle(3);
    mcycle(1, 16'h0605, 16'h5678, 0, '0, 0);
    mcycle(1, 16'h0807, 16'h5678, 0, '0, 0);
    idle(1);
    // Three vectors with a one-cycle bubble between the first and second.
    mcycle(0, '0, '0, 1, 32'h04030201, 0);
    mcycle(0, '0, '0, 0, '0, 0);
    mcycle(0, '0, '0, 1, 32'h14131211, 0);
    mcycle(0, '0, '0, 1, 32'h24232221, 1);
    idle(ROWS + 2);
    chk("gap_switch_cycle", 64'(sw_cyc), 64'(t0 + 8));

    // Reset in the middle of STREAM, then a normal tile.
    for (int k = 0; k < ROWS; k++) mcycle(1, 16'(16'h1111 * (k + 1)), 16'h00AA, 0, '0, 0);
    idle(1);
    mcycle(0, '0, '0, 1, 32'hA1A2A3A4, 0);
    mcycle(0, '0, '0, 1, 32'hB1B2B3B4, 0);
    do_reset();
    for (int k = 0; k < ROWS; k++) mcycle(1, 16'(16'h2222 * (k + 1)), 16'h00BB, 0, '0, 0);
    idle(1);
    mcycle(0, '0, '0, 1, 32'hC1C2C3C4, 1);
    idle(ROWS + 2);

    // Random traffic, valids asserted in every state.
    for (int i = 0; i < 700; i++) begin
      if (i == 350) do_reset();
      mcycle($urandom_range(0, 99) < 60, 16'($urandom), 16'($urandom),
             $urandom_range(0, 99) < 60, 32'($urandom), $urandom_range(0, 4) == 0);
    end
    idle(ROWS + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
